calc_serial_rx: RTL and testbench
=================================

Name: calc_serial_rx

Overview:
- Receive-side counterpart of the calculator's serial result transmitter.
- Deserializes the DataOut/ClkTx/DOutValid stream back into OUTSIZE-bit result words and buffers them in a small first-word-fall-through FIFO for a downstream checker or host.
- Sits on the same Clk as the calculator top and samples ClkTx as a data signal. No clock-domain crossing.

Parameters:
OUTSIZE, 8, result word width in bits (matches calculator OUTSIZE)
DEPTH, 4, FIFO depth in words (power of 2, >=2)
TIMEOUT, 64, max Clk cycles between ClkTx rising edges while receiving (used only with CALC_RX_TIMEOUT_EN)

Ports:
Clk  input  1  system clock, all logic on posedge
Reset  input  1  synchronous, active-high reset
ClkTx  input  1  divided transmit clock from calculator
DOutValid  input  1  high while a word is being shifted out
DataOut  input  1  serial data bit, MSB first
RdEn  input  1  pop head word when RxValid=1
ClrErr  input  1  clears sticky Overrun
RxData  output  OUTSIZE  FIFO head word
RxValid  output  1  FIFO not empty
RxLevel  output  $clog2(DEPTH)+1  words stored
RxBusy  output  1  word reception in progress (state SHIFT)
FrameErr  output  1  one-cycle pulse: aborted/short frame
Overrun  output  1  sticky: complete word dropped because FIFO full

Behaviour:
- Reset is synchronous, active-high, and has priority over all other inputs.
  - Reset clears state to IDLE, BitCnt=0, shift reg=0, ClkTx_q=0, FIFO pointers/count=0.
  - Output reset values: RxData=0, RxValid=0, RxLevel=0, RxBusy=0, FrameErr=0, Overrun=0.
  - Reset mid-word discards the partial word with no FrameErr.
- Edge detect: ClkTx_q <= ClkTx each cycle. Sample event = ClkTx & ~ClkTx_q & DOutValid.
- FSM has 2 states.
  - IDLE: on a sample event, shift reg <= {.., DataOut}, BitCnt=1, go to SHIFT.
    - If OUTSIZE==1, the word completes immediately (push rules below) and the FSM stays in IDLE.
    - DOutValid high without a ClkTx edge does nothing.
  - SHIFT: on a sample event, shift left and insert DataOut at the LSB, then BitCnt++.
    - When BitCnt reaches OUTSIZE, the word is complete: push and return to IDLE.
  - SHIFT abort: DOutValid=0 on any cycle while in SHIFT → FrameErr=1 for exactly one cycle, word discarded, go to IDLE.
- Push timing: the push happens on the same posedge that samples the last bit. RxValid/RxLevel reflect the new word on the next cycle (1-cycle latency).
- FIFO behaviour:
  - RxData shows the head word whenever RxValid=1. RxData is 0 when the FIFO is empty.
  - RdEn with RxValid=0 is ignored; no underflow.
  - Push when full and no pop: word dropped, Overrun<=1.
  - Push and pop in the same cycle when full: both succeed, level unchanged, no Overrun.
  - Push and pop in the same cycle when empty: the new word is written. The pop is ignored because RxValid was 0.
  - Pointers wrap modulo DEPTH.
- Overrun clears only on ClrErr or Reset. ClrErr and a new overrun in the same cycle → Overrun stays 1.
- RxBusy = (state==SHIFT).
- ClkTx frequency changes between or within words are tolerated, since only edges are counted.

Optional Feature:
- Macro: CALC_RX_TIMEOUT_EN.
- When defined:
  - A watchdog counter is reset on each sample event and on entry to SHIFT, and increments every cycle in SHIFT.
  - If it reaches TIMEOUT, the FSM aborts exactly like a DOutValid drop: one-cycle FrameErr, partial word discarded, return to IDLE.
- When undefined: no counter. SHIFT waits indefinitely while DOutValid=1.

Test Plan:
- Reset held 3 cycles mid-word (after 4 bits of 0xA5) → all outputs 0, RxLevel=0, no FrameErr; next full 0x3C frame received as RxData=0x3C.
- Send 0xA5 with ClkTx = Clk/2, then 0x5A with ClkTx = Clk/5 → RxLevel=2; pops return 0xA5 then 0x5A; FrameErr never asserted.
- Send 5 words 0x01..0x05 with DEPTH=4 and no reads → RxLevel=4, Overrun=1, pops return 0x01..0x04; ClrErr → Overrun=0; sixth RdEn with RxValid=0 → no change.
- DOutValid dropped after 5 bits → FrameErr high for exactly 1 cycle, RxLevel unchanged, RxBusy=0 next cycle; following 0xFF frame received correctly.
- FIFO full, final bit of 0x77 sampled in the same cycle as RdEn → level stays 4, no Overrun, 0x77 is the last word out.
- CALC_RX_TIMEOUT_EN, TIMEOUT=64: ClkTx stopped after 3 bits with DOutValid=1 → FrameErr pulse 64 cycles after the last edge, FSM back in IDLE.

Source files
------------

// File: rtl/calc_serial_rx_if.sv
// Purpose: bundles the serial receive stream, the FIFO read side and the status flags of calc_serial_rx.
// Latency: none; this is wiring only.
// Backpressure: none of its own. RdEn pops the FIFO head only while RxValid is high.
// Ports (slave = receiver view):
//   in  : ClkTx, DOutValid, DataOut (serial stream); RdEn, ClrErr (host controls)
//   out : RxData, RxValid, RxLevel (FIFO head/state); RxBusy, FrameErr, Overrun (status)
interface calc_serial_rx_if #(
    parameter int OUTSIZE = 8,
    parameter int DEPTH   = 4
);
    logic                     ClkTx;
    logic                     DOutValid;
    logic                     DataOut;
    logic                     RdEn;
    logic                     ClrErr;
    logic [OUTSIZE-1:0]       RxData;
    logic                     RxValid;
    logic [$clog2(DEPTH):0]   RxLevel;
    logic                     RxBusy;
    logic                     FrameErr;
    logic                     Overrun;

    modport master (
        output ClkTx, DOutValid, DataOut, RdEn, ClrErr,
        input  RxData, RxValid, RxLevel, RxBusy, FrameErr, Overrun
    );

    modport slave (
        input  ClkTx, DOutValid, DataOut, RdEn, ClrErr,
        output RxData, RxValid, RxLevel, RxBusy, FrameErr, Overrun
    );
endinterface

// File: rtl/calc_serial_rx.sv
// Purpose: deserializes the calculator's DataOut/ClkTx/DOutValid stream into OUTSIZE-bit words held in a FWFT FIFO.
// Latency: a word is pushed on the edge that samples its last bit and is visible on RxData/RxValid one cycle later.
// Backpressure: none toward the transmitter. A word completed while the FIFO is full, with no pop, is dropped and sets the sticky Overrun.
// Ports: Clk, Reset (sync, active-high), rx (calc_serial_rx_if.slave).
// Optional macro CALC_RX_TIMEOUT_EN adds a watchdog that aborts a word after TIMEOUT cycles without a ClkTx edge.
module calc_serial_rx #(
    parameter int OUTSIZE = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input logic             Clk,
    input logic             Reset,
    calc_serial_rx_if.slave rx
);
    localparam int CW = $clog2(OUTSIZE + 1);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || OUTSIZE < 1) begin : g_bad_param
        $error("calc_serial_rx: DEPTH must be a power of 2 >= 2, TIMEOUT and OUTSIZE >= 1");
    end

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      bit_cnt, cnt_nxt;
    logic [OUTSIZE-1:0] shift_reg, shift_d, shift_in;
    logic               clk_tx_q;
    logic               sample;
    logic               push;
    logic               abort;
    logic               wd_expired;
    logic               frame_err;
    logic               overrun;

    logic [OUTSIZE-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               pop, do_write, full;

    // ClkTx is treated as data; a bit is taken on its rising edge while the frame is valid.
    assign sample   = rx.ClkTx & ~clk_tx_q & rx.DOutValid;
    assign shift_in = OUTSIZE'({shift_reg, rx.DataOut});

`ifdef CALC_RX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_cnt;

    // Counter stays at 0 outside SHIFT, so entering SHIFT starts it from zero.
    always_ff @(posedge Clk) begin
        if (Reset || state != SHIFT || sample) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WW'(1);
        end
    end

    // Fires on the cycle the counter would reach TIMEOUT.
    assign wd_expired = (state == SHIFT) && !sample && (wd_cnt == WW'(TIMEOUT - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            clk_tx_q  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= cnt_nxt;
            shift_reg <= shift_d;
            clk_tx_q  <= rx.ClkTx;
            frame_err <= abort;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shift_d   = shift_reg;
        push      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (sample) begin
                    shift_d = shift_in;
                    if (OUTSIZE == 1) begin
                        push    = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt   = CW'(1);
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (!rx.DOutValid || wd_expired) begin
                    abort     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (sample) begin
                    shift_d = shift_in;
                    cnt_nxt = bit_cnt + CW'(1);
                    if (bit_cnt == CW'(OUTSIZE - 1)) begin
                        push      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO: a pop on an empty FIFO is ignored; a simultaneous pop makes room for a push when full.
    assign full     = (count == (AW + 1)'(DEPTH));
    assign pop      = rx.RdEn && (count != '0);
    assign do_write = push && (!full || pop);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            if (do_write && !pop)      count <= count + (AW + 1)'(1);
            else if (pop && !do_write) count <= count - (AW + 1)'(1);
            // A new overrun wins over a clear in the same cycle.
            if (push && !do_write)     overrun <= 1'b1;
            else if (rx.ClrErr)        overrun <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_write) mem[wr_ptr] <= shift_in;
    end

    assign rx.RxData   = (count != '0) ? mem[rd_ptr] : '0;
    assign rx.RxValid  = (count != '0);
    assign rx.RxLevel  = count;
    assign rx.RxBusy   = (state == SHIFT);
    assign rx.FrameErr = frame_err;
    assign rx.Overrun  = overrun;
endmodule

// File: tb/tb_calc_serial_rx.sv
// Purpose: directed self-checking bench for calc_serial_rx (OUTSIZE=8, DEPTH=4, TIMEOUT=64).
// Latency: inputs change 1 time unit after a rising Clk edge, and outputs are checked at that same point.
// Backpressure: the host side pops explicitly through RdEn.
module tb_calc_serial_rx;
    logic Clk;
    logic Reset;
    int   errors = 0;
    int   checks = 0;
    int   fe_cnt = 0;
    int   fe_base;

    calc_serial_rx_if #(.OUTSIZE(8), .DEPTH(4)) rxif ();

    calc_serial_rx #(.OUTSIZE(8), .DEPTH(4), .TIMEOUT(64)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .rx    (rxif)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Counts FrameErr pulses, sampled mid-cycle.
    always @(negedge Clk) if (rxif.FrameErr === 1'b1) fe_cnt++;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends the top n bits of w, MSB first, with ClkTx = Clk/div. It leaves DOutValid=1 and ClkTx high.
    task automatic send_bits(input logic [7:0] w, input int n, input int div);
        rxif.DOutValid = 1'b1;
        for (int i = 0; i < n; i++) begin
            rxif.DataOut = w[7-i];
            rxif.ClkTx   = 1'b0;
            repeat (div - div / 2) step();
            rxif.ClkTx   = 1'b1;
            repeat (div / 2) step();
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int div);
        send_bits(w, 8, div);
        rxif.DOutValid = 1'b0;
        rxif.ClkTx     = 1'b0;
        rxif.DataOut   = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {31'd0, rxif.RxValid}, 32'd1);
        chk(tag, {24'd0, rxif.RxData}, {24'd0, exp});
        rxif.RdEn = 1'b1;
        step();
        rxif.RdEn = 1'b0;
    endtask

    initial begin
        Reset          = 1'b1;
        rxif.ClkTx     = 1'b0;
        rxif.DOutValid = 1'b0;
        rxif.DataOut   = 1'b0;
        rxif.RdEn      = 1'b0;
        rxif.ClrErr    = 1'b0;
        repeat (3) step();
        chk("rst_rxdata",  {24'd0, rxif.RxData}, 32'h0);
        chk("rst_rxvalid", {31'd0, rxif.RxValid}, 32'd0);
        chk("rst_level",   {29'd0, rxif.RxLevel}, 32'd0);
        chk("rst_busy",    {31'd0, rxif.RxBusy}, 32'd0);
        chk("rst_overrun", {31'd0, rxif.Overrun}, 32'd0);
        Reset = 1'b0;

        // Reset held mid-word discards the partial word silently.
        send_bits(8'hA5, 4, 2);
        chk("mid_busy", {31'd0, rxif.RxBusy}, 32'd1);
        fe_base    = fe_cnt;
        Reset      = 1'b1;
        rxif.ClkTx = 1'b0;
        repeat (3) begin
            step();
            chk("mid_rst_fe", {31'd0, rxif.FrameErr}, 32'd0);
        end
        Reset          = 1'b0;
        rxif.DOutValid = 1'b0;
        step();
        chk("mid_rst_busy",  {31'd0, rxif.RxBusy}, 32'd0);
        chk("mid_rst_level", {29'd0, rxif.RxLevel}, 32'd0);
        chk("mid_rst_data",  {24'd0, rxif.RxData}, 32'h0);
        chk("mid_rst_fe_cnt", fe_cnt - fe_base, 32'd0);
        send_word(8'h3C, 2);
        chk("post_rst_level", {29'd0, rxif.RxLevel}, 32'd1);
        pop_chk("post_rst_word", 8'h3C);
        chk("post_pop_level", {29'd0, rxif.RxLevel}, 32'd0);

        // Two words at different ClkTx rates.
        fe_base = fe_cnt;
        send_word(8'hA5, 2);
        step();
        send_word(8'h5A, 5);
        step();
        chk("rate_level", {29'd0, rxif.RxLevel}, 32'd2);
        pop_chk("rate_w0", 8'hA5);
        pop_chk("rate_w1", 8'h5A);
        chk("rate_no_fe", fe_cnt - fe_base, 32'd0);

        // Overflow: five words into a four-deep FIFO.
        for (int k = 1; k <= 5; k++) begin
            send_word(k[7:0], 2);
            step();
        end
        chk("ovf_level",   {29'd0, rxif.RxLevel}, 32'd4);
        chk("ovf_overrun", {31'd0, rxif.Overrun}, 32'd1);
        pop_chk("ovf_w1", 8'h01);
        pop_chk("ovf_w2", 8'h02);
        pop_chk("ovf_w3", 8'h03);
        pop_chk("ovf_w4", 8'h04);
        chk("ovf_sticky", {31'd0, rxif.Overrun}, 32'd1);
        rxif.ClrErr = 1'b1;
        step();
        rxif.ClrErr = 1'b0;
        chk("ovf_clr", {31'd0, rxif.Overrun}, 32'd0);
        rxif.RdEn = 1'b1;
        step();
        rxif.RdEn = 1'b0;
        chk("underflow_level", {29'd0, rxif.RxLevel}, 32'd0);
        chk("underflow_valid", {31'd0, rxif.RxValid}, 32'd0);
        chk("underflow_data",  {24'd0, rxif.RxData}, 32'h0);

        // A DOutValid drop after 5 bits gives one FrameErr cycle.
        send_bits(8'hC3, 5, 2);
        rxif.DOutValid = 1'b0;
        rxif.ClkTx     = 1'b0;
        step();
        chk("abort_fe",    {31'd0, rxif.FrameErr}, 32'd1);
        chk("abort_busy",  {31'd0, rxif.RxBusy}, 32'd0);
        chk("abort_level", {29'd0, rxif.RxLevel}, 32'd0);
        step();
        chk("abort_fe_end", {31'd0, rxif.FrameErr}, 32'd0);
        send_word(8'hFF, 2);
        step();
        pop_chk("abort_next", 8'hFF);

        // Full FIFO with a pop on the same edge as the last bit of 0x77.
        send_word(8'h10, 2);
        send_word(8'h20, 2);
        send_word(8'h30, 2);
        send_word(8'h40, 2);
        chk("simul_full", {29'd0, rxif.RxLevel}, 32'd4);
        send_bits(8'h77, 7, 2);
        rxif.DataOut = 1'b1;
        rxif.ClkTx   = 1'b0;
        step();
        rxif.ClkTx = 1'b1;
        rxif.RdEn  = 1'b1;
        step();
        rxif.RdEn      = 1'b0;
        rxif.DOutValid = 1'b0;
        rxif.ClkTx     = 1'b0;
        chk("simul_level",   {29'd0, rxif.RxLevel}, 32'd4);
        chk("simul_overrun", {31'd0, rxif.Overrun}, 32'd0);
        pop_chk("simul_w0", 8'h20);
        pop_chk("simul_w1", 8'h30);
        pop_chk("simul_w2", 8'h40);
        pop_chk("simul_w3", 8'h77);
        chk("simul_empty", {29'd0, rxif.RxLevel}, 32'd0);

`ifdef CALC_RX_TIMEOUT_EN
        // ClkTx stalls after 3 bits; the watchdog aborts 64 cycles after the last edge.
        send_bits(8'hA5, 3, 2);
        repeat (63) step();
        chk("wd_before_fe",   {31'd0, rxif.FrameErr}, 32'd0);
        chk("wd_before_busy", {31'd0, rxif.RxBusy}, 32'd1);
        step();
        chk("wd_fe",   {31'd0, rxif.FrameErr}, 32'd1);
        chk("wd_busy", {31'd0, rxif.RxBusy}, 32'd0);
        rxif.DOutValid = 1'b0;
        rxif.ClkTx     = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
